osc_bank: RTL and testbench
===========================

Name: osc_bank

Overview:
- Parametrised multi-channel square-wave oscillator bank; successor to the single-channel note oscillator.
- CH_N independent channels, each with its own half-period register, phase counter, enable flag and wave output.
- Adds a registered mix output (count of high waves) and an active-voice count for the downstream DAC/PWM stage.
- Sits between the MIDI note decoder (strobes, channel mask, half-period from the note LUT) and the audio output stage.

Parameters:
- CH_N, 4, number of oscillator channels (1..16).
- CNT_BW, 16, width of the half-period register and phase counter per channel.
- MIX_BW, 3, width of mix_o and activeCnt_o; must satisfy 2^MIX_BW > CH_N.

Ports:
- clk_i  in  1  system clock.
- nrst_i  in  1  reset; asynchronous, active-low.
- noteOnStrb_i  in  1  one-cycle note-on strobe.
- noteOffStrb_i  in  1  one-cycle note-off strobe.
- ch_i  in  CH_N  channel mask; multi-hot allowed; strobes apply to every set bit.
- halfCntPeriod_i  in  CNT_BW  half-period in clocks minus 1; sampled on note-on.
- active_o  out  CH_N  per-channel enable flags.
- wave_o  out  CH_N  per-channel square wave.
- mix_o  out  MIX_BW  registered count of channels with active=1 and wave=1.
- activeCnt_o  out  MIX_BW  registered popcount of active_o.

Behaviour:
- Reset values (asynchronous): active, wave, phase counters, half-period registers, mix_o and activeCnt_o are all 0.
- Per channel k, evaluated on each rising clk_i:
  - Note-on (noteOnStrb_i & ch_i[k]): active<=1, period<=halfCntPeriod_i, cnt<=0, wave unchanged.
  - Note-on to an already active channel is a retrigger: same action; phase restarts, no wave glitch.
  - Note-off (noteOffStrb_i & ch_i[k] & !noteOnStrb_i): active<=0, cnt<=0, wave<=0.
  - Both strobes asserted in the same cycle: note-on wins.
  - Active, no strobe: if cnt==period, then cnt<=0 and wave<=~wave; else cnt<=cnt+1.
  - Inactive: cnt and wave held at 0.
- Output frequency = f_clk / (2*(period+1)).
  - period=0: wave toggles every clock.
  - period=2^CNT_BW-1: maximum period; the counter never overflows because the compare occurs first.
- First toggle after note-on occurs period+1 clocks after the strobe edge.
- mix_o = popcount(wave_o & active_o) and activeCnt_o = popcount(active_o), each registered with exactly 1 clock latency.
- Channels are fully independent; no interaction except through the shared strobe/mask/period inputs.
- Deasserting nrst_i mid-operation clears every channel immediately; no state survives.

Optional Feature:
- Macro: OSC_BANK_GLIDE_EN.
- Defined: each channel has an extra CNT_BW target register.
  - Note-on to an inactive channel: period and target both load halfCntPeriod_i (immediate pitch).
  - Note-on to an active channel: only target loads; cnt and wave are untouched.
  - At each toggle event where period != target, period steps by 1 toward target. Glide is one step per half-cycle until equal.
  - Note-off clears nothing in target; the next note-on overwrites it.
- Not defined: no target registers; every note-on loads period directly as described under Behaviour.

Test Plan:
- Reset, then note-on ch_i=4'b0001, period=3 -> wave_o[0] toggles every 4 clocks (8-clock period); active_o=4'b0001; activeCnt_o=1 one clock later.
- Note-on ch_i=4'b0110, period=0 -> wave_o[1] and wave_o[2] toggle every clock, in phase; mix_o alternates 0/2 with 1-clock lag.
- Simultaneous noteOn and noteOff on ch_i=4'b1000 -> channel 3 becomes active; later noteOff alone -> active_o[3]=0 and wave_o[3]=0 next clock.
- Retrigger channel 0 mid-cycle with period=1 while wave=1 -> wave stays 1, then toggles 2 clocks later, then every 2 clocks.
- Assert nrst_i low while 4 channels are active and mixing -> all outputs 0 asynchronously, before the next edge.
- GLIDE_EN: active channel 0 at period=10, note-on with period=7 -> successive half-cycle lengths 11,10,9,8,8,... clocks.

Source files
------------

// File: rtl/osc_bank.sv
// Multi-channel square-wave oscillator bank with registered mix and active-voice counts.
// Optional pitch glide on retrigger is enabled by defining OSC_BANK_GLIDE_EN.
module osc_bank #(
  parameter int unsigned CH_N   = 4,
  parameter int unsigned CNT_BW = 16,
  parameter int unsigned MIX_BW = 3
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              noteOnStrb_i,
  input  logic              noteOffStrb_i,
  input  logic [CH_N-1:0]   ch_i,
  input  logic [CNT_BW-1:0] halfCntPeriod_i,
  output logic [CH_N-1:0]   active_o,
  output logic [CH_N-1:0]   wave_o,
  output logic [MIX_BW-1:0] mix_o,
  output logic [MIX_BW-1:0] activeCnt_o
);

  logic [CH_N-1:0] active;
  logic [CH_N-1:0] wave;

  for (genvar k = 0; k < CH_N; k++) begin : g_ch
    logic              on_hit;
    logic              off_hit;
    logic              active_q;
    logic              wave_q;
    logic [CNT_BW-1:0] cnt_q;
    logic [CNT_BW-1:0] period_q;
`ifdef OSC_BANK_GLIDE_EN
    logic [CNT_BW-1:0] target_q;
`endif

    assign on_hit  = noteOnStrb_i & ch_i[k];
    // Note-on has priority when both strobes arrive together.
    assign off_hit = noteOffStrb_i & ch_i[k] & ~noteOnStrb_i;

    always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
        active_q <= 1'b0;
        wave_q   <= 1'b0;
        cnt_q    <= '0;
        period_q <= '0;
`ifdef OSC_BANK_GLIDE_EN
        target_q <= '0;
`endif
      end else if (on_hit) begin
`ifdef OSC_BANK_GLIDE_EN
        target_q <= halfCntPeriod_i;
        // A playing voice keeps its phase and glides; a silent one starts at pitch.
        if (!active_q) begin
          active_q <= 1'b1;
          period_q <= halfCntPeriod_i;
          cnt_q    <= '0;
        end else if (cnt_q == period_q) begin
          cnt_q  <= '0;
          wave_q <= ~wave_q;
          if (period_q < halfCntPeriod_i) begin
            period_q <= period_q + CNT_BW'(1);
          end else if (period_q > halfCntPeriod_i) begin
            period_q <= period_q - CNT_BW'(1);
          end
        end else begin
          cnt_q <= cnt_q + CNT_BW'(1);
        end
`else
        active_q <= 1'b1;
        period_q <= halfCntPeriod_i;
        cnt_q    <= '0;
`endif
      end else if (off_hit) begin
        active_q <= 1'b0;
        wave_q   <= 1'b0;
        cnt_q    <= '0;
      end else if (active_q) begin
        // Compare before increment, so a full-scale period never wraps the counter.
        if (cnt_q == period_q) begin
          cnt_q  <= '0;
          wave_q <= ~wave_q;
`ifdef OSC_BANK_GLIDE_EN
          if (period_q < target_q) begin
            period_q <= period_q + CNT_BW'(1);
          end else if (period_q > target_q) begin
            period_q <= period_q - CNT_BW'(1);
          end
`endif
        end else begin
          cnt_q <= cnt_q + CNT_BW'(1);
        end
      end else begin
        cnt_q  <= '0;
        wave_q <= 1'b0;
      end
    end

    assign active[k] = active_q;
    assign wave[k]   = wave_q;
  end

  logic [MIX_BW-1:0] mix_d;
  logic [MIX_BW-1:0] act_cnt_d;
  logic [MIX_BW-1:0] mix_q;
  logic [MIX_BW-1:0] act_cnt_q;

  always_comb begin
    mix_d     = '0;
    act_cnt_d = '0;
    for (int k = 0; k < CH_N; k++) begin
      mix_d     = mix_d + MIX_BW'(wave[k] & active[k]);
      act_cnt_d = act_cnt_d + MIX_BW'(active[k]);
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      mix_q     <= '0;
      act_cnt_q <= '0;
    end else begin
      mix_q     <= mix_d;
      act_cnt_q <= act_cnt_d;
    end
  end

  assign active_o    = active;
  assign wave_o      = wave;
  assign mix_o       = mix_q;
  assign activeCnt_o = act_cnt_q;

endmodule

// File: tb/tb_osc_bank.sv
// Directed table-driven bench for osc_bank (CH_N=4, CNT_BW=16, MIX_BW=3).
module tb_osc_bank;

  logic        clk;
  logic        nrst;
  logic        note_on;
  logic        note_off;
  logic [3:0]  ch;
  logic [15:0] per;
  logic [3:0]  active;
  logic [3:0]  wave;
  logic [2:0]  mix;
  logic [2:0]  act_cnt;

  int total = 0;
  int bad   = 0;

  osc_bank #(.CH_N(4), .CNT_BW(16), .MIX_BW(3)) dut (
    .clk_i          (clk),
    .nrst_i         (nrst),
    .noteOnStrb_i   (note_on),
    .noteOffStrb_i  (note_off),
    .ch_i           (ch),
    .halfCntPeriod_i(per),
    .active_o       (active),
    .wave_o         (wave),
    .mix_o          (mix),
    .activeCnt_o    (act_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        on;
    logic        off;
    logic [3:0]  ch;
    logic [15:0] per;
    logic [3:0]  act;
    logic [3:0]  wave;
    logic [2:0]  mix;
    logic [2:0]  ac;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic on, input logic off, input logic [3:0] c, input logic [15:0] p,
                     input logic [3:0] a, input logic [3:0] w, input logic [2:0] m,
                     input logic [2:0] n);
    vec_t r;
    r.on = on; r.off = off; r.ch = c; r.per = p;
    r.act = a; r.wave = w; r.mix = m; r.ac = n;
    vq.push_back(r);
  endtask

  task automatic idle(input logic [3:0] a, input logic [3:0] w, input logic [2:0] m,
                      input logic [2:0] n);
    add(1'b0, 1'b0, 4'b0000, 16'd0, a, w, m, n);
  endtask

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int last_row;
  int len;
  logic prev_w;
  int glide_len[5];

  initial begin
    nrst = 1'b0; note_on = 1'b0; note_off = 1'b0; ch = '0; per = '0;

    // ch0 at period 3: 4-clock half cycles
    add(1, 0, 4'b0001, 16'd3, 4'b0001, 4'b0000, 0, 0);
    idle(4'b0001, 4'b0000, 0, 1);
    idle(4'b0001, 4'b0000, 0, 1);
    idle(4'b0001, 4'b0000, 0, 1);
    idle(4'b0001, 4'b0001, 0, 1);
    idle(4'b0001, 4'b0001, 1, 1);
    idle(4'b0001, 4'b0001, 1, 1);
    idle(4'b0001, 4'b0001, 1, 1);
    idle(4'b0001, 4'b0000, 1, 1);
    idle(4'b0001, 4'b0000, 0, 1);
    // ch1+ch2 at period 0: toggle every clock, in phase
    add(1, 0, 4'b0110, 16'd0, 4'b0111, 4'b0000, 0, 1);
    idle(4'b0111, 4'b0110, 0, 3);
    idle(4'b0111, 4'b0001, 2, 3);
    idle(4'b0111, 4'b0111, 1, 3);
    idle(4'b0111, 4'b0001, 3, 3);
    idle(4'b0111, 4'b0111, 1, 3);
    idle(4'b0111, 4'b0000, 3, 3);
    idle(4'b0111, 4'b0110, 0, 3);
    // on+off together on ch3: on wins
    add(1, 1, 4'b1000, 16'd2, 4'b1111, 4'b0000, 2, 3);
    idle(4'b1111, 4'b0110, 0, 4);
    idle(4'b1111, 4'b0001, 2, 4);
    idle(4'b1111, 4'b1111, 1, 4);
    add(0, 1, 4'b1000, 16'd0, 4'b0111, 4'b0001, 4, 4);
    idle(4'b0111, 4'b0111, 1, 3);
    idle(4'b0111, 4'b0000, 3, 3);
    idle(4'b0111, 4'b0110, 0, 3);
    idle(4'b0111, 4'b0000, 2, 3);
    idle(4'b0111, 4'b0110, 0, 3);
    idle(4'b0111, 4'b0001, 2, 3);
    idle(4'b0111, 4'b0111, 1, 3);
    // retrigger ch0 at period 1 while its wave is high
    add(1, 0, 4'b0001, 16'd1, 4'b0111, 4'b0001, 3, 3);
    idle(4'b0111, 4'b0111, 1, 3);
    idle(4'b0111, 4'b0000, 3, 3);
    idle(4'b0111, 4'b0110, 0, 3);
    idle(4'b0111, 4'b0001, 2, 3);
    idle(4'b0111, 4'b0111, 1, 3);
    add(1, 0, 4'b1000, 16'd0, 4'b1111, 4'b0000, 3, 3);
    idle(4'b1111, 4'b1110, 0, 4);
    idle(4'b1111, 4'b0001, 3, 4);

`ifdef OSC_BANK_GLIDE_EN
    last_row = 30;  // later rows retrigger active voices, which glide instead
`else
    last_row = vq.size();
`endif

    #2;
    check("reset active", int'(active), 0);
    check("reset wave", int'(wave), 0);
    check("reset mix", int'(mix), 0);
    check("reset actcnt", int'(act_cnt), 0);
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < last_row; i++) begin
      note_on = vq[i].on; note_off = vq[i].off; ch = vq[i].ch; per = vq[i].per;
      tick();
      check($sformatf("row%0d active", i + 1), int'(active), int'(vq[i].act));
      check($sformatf("row%0d wave", i + 1), int'(wave), int'(vq[i].wave));
      check($sformatf("row%0d mix", i + 1), int'(mix), int'(vq[i].mix));
      check($sformatf("row%0d actcnt", i + 1), int'(act_cnt), int'(vq[i].ac));
    end
    note_on = 1'b0; note_off = 1'b0; ch = '0; per = '0;

    // Asynchronous reset between edges while voices are mixing
    #2;
    nrst = 1'b0;
    #1;
    check("async active", int'(active), 0);
    check("async wave", int'(wave), 0);
    check("async mix", int'(mix), 0);
    check("async actcnt", int'(act_cnt), 0);
    @(negedge clk);
    nrst = 1'b1;
    tick();
    tick();
    check("post-reset active", int'(active), 0);
    check("post-reset actcnt", int'(act_cnt), 0);

    // Full-scale period on ch1: first toggle 65536 clocks after the strobe
    note_on = 1'b1; ch = 4'b0010; per = 16'hFFFF;
    tick();
    note_on = 1'b0; ch = '0; per = '0;
    for (int i = 1; i < 65536; i++) tick();
    check("maxper before toggle", int'(wave[1]), 0);
    check("maxper still active", int'(active[1]), 1);
    tick();
    check("maxper toggle", int'(wave[1]), 1);
    tick();
    check("maxper no wrap", int'(wave[1]), 1);

`ifdef OSC_BANK_GLIDE_EN
    nrst = 1'b0;
    #1;
    nrst = 1'b1;
    note_on = 1'b1; ch = 4'b0001; per = 16'd10;
    tick();
    note_on = 1'b0;
    len = 0;
    while (wave[0] == 1'b0 && len < 40) begin
      tick();
      len++;
    end
    check("glide first toggle", len, 11);
    note_on = 1'b1; per = 16'd7;
    glide_len = '{11, 10, 9, 8, 8};
    for (int h = 0; h < 5; h++) begin
      prev_w = wave[0];
      len = 0;
      do begin
        tick();
        note_on = 1'b0;
        len++;
      end while (wave[0] == prev_w && len < 40);
      check($sformatf("glide half%0d", h), len, glide_len[h]);
    end
    note_on = 1'b0; ch = '0; per = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
